// File: rtl/vram_text_console.sv
// Byte-stream to VRAM write-port converter for a 32x32 text screen: cursor
// tracking, auto-wrap, line clearing and hardware vertical scroll.
module vram_text_console #(
    parameter logic [7:0]  C_FILL_CHR  = 8'h20,
    parameter int unsigned C_LF_CR     = 1,
    parameter int unsigned C_AUTO_WRAP = 1
) (
    input  logic       CK_i,
    input  logic       AR_i,
    input  logic       CK_EE_i,
    input  logic [7:0] DAT_i,
    input  logic       DAT_VALID_i,
    output logic       DAT_READY_o,
    output logic [7:0] VRAM_WDs_o,
    output logic [9:0] VRAM_WAs_o,
    output logic       VRAM_WE_o,
    output logic [7:0] V_SCROLLs_o,
    output logic [4:0] CUR_COLs_o,
    output logic [4:0] CUR_ROWs_o,
    output logic       BUSY_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLR_LINE,
        ST_CLR_ALL
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [4:0] top_q, top_d;
    logic [9:0] ctr_q, ctr_d;
    logic       we_q, we_d;
    logic [7:0] wd_q, wd_d;
    logic [9:0] wa_q, wa_d;
    logic [7:0] vs_q, vs_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;

    logic [4:0] prow;
    logic [4:0] top_inc;
    logic       accept;
    logic       newline;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        top_d   = top_q;
        ctr_d   = ctr_q;
        we_d    = 1'b0;
        wd_d    = wd_q;
        wa_d    = wa_q;
        vs_d    = vs_q;
        newline = 1'b0;
        prow    = top_q + row_q;
        top_inc = top_q + 5'd1;
        accept  = DAT_VALID_i && ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (DAT_i >= 8'h20) begin
                        we_d    = 1'b1;
                        wd_d    = DAT_i;
                        wa_d    = {prow, col_q};
                        state_d = ST_WRITE;
                    end else begin
                        // Non-printing codes pass through WRITE without a strobe
                        // so READY always drops for one enable after acceptance.
                        state_d = ST_WRITE;
                        case (DAT_i)
                            8'h0D: col_d = '0;
                            8'h0A: begin
                                newline = 1'b1;
                                if (C_LF_CR != 0) col_d = '0;
                            end
                            8'h08: if (col_q != '0) col_d = col_q - 5'd1;
                            8'h0C: begin
                                col_d   = '0;
                                row_d   = '0;
                                top_d   = '0;
                                vs_d    = '0;
                                ctr_d   = '0;
                                state_d = ST_CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (we_q) begin
                    if (col_q != 5'd31) begin
                        col_d = col_q + 5'd1;
                    end else if (C_AUTO_WRAP != 0) begin
                        col_d   = '0;
                        newline = 1'b1;
                    end
                end
            end
            ST_CLR_LINE: begin
                we_d  = 1'b1;
                wd_d  = C_FILL_CHR;
                wa_d  = {prow, ctr_q[4:0]};
                ctr_d = ctr_q + 10'd1;
                if (ctr_q[4:0] == 5'd31) state_d = ST_IDLE;
            end
            ST_CLR_ALL: begin
                we_d  = 1'b1;
                wd_d  = C_FILL_CHR;
                wa_d  = ctr_q;
                ctr_d = ctr_q + 10'd1;
                if (ctr_q == 10'd1023) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (newline) begin
            if (row_q != 5'd31) begin
                row_d   = row_q + 5'd1;
                state_d = (state_q == ST_IDLE) ? ST_WRITE : ST_IDLE;
            end else begin
                top_d   = top_inc;
                vs_d    = {top_inc, 3'b000};
                ctr_d   = '0;
                state_d = ST_CLR_LINE;
            end
        end

        // After a clear, READY and BUSY change one enable late, together with WE falling.
        ready_d = (state_d == ST_IDLE) && (state_q == ST_IDLE || state_q == ST_WRITE);
        busy_d  = (state_d == ST_CLR_LINE) || (state_d == ST_CLR_ALL) ||
                  (state_q == ST_CLR_LINE) || (state_q == ST_CLR_ALL);
    end

    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            state_q <= ST_CLR_ALL;
            col_q   <= '0;
            row_q   <= '0;
            top_q   <= '0;
            ctr_q   <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            wa_q    <= '0;
            vs_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else if (CK_EE_i) begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            top_q   <= top_d;
            ctr_q   <= ctr_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            wa_q    <= wa_d;
            vs_q    <= vs_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign DAT_READY_o = ready_q;
    assign VRAM_WDs_o  = wd_q;
    assign VRAM_WAs_o  = wa_q;
    assign VRAM_WE_o   = we_q;
    assign V_SCROLLs_o = vs_q;
    assign CUR_COLs_o  = col_q;
    assign CUR_ROWs_o  = row_q;
    assign BUSY_o      = busy_q;

endmodule

// File: doc/vram_text_console.md
Name: vram_text_console

Overview:
- Upstream feeder for the character generator's VRAM write port. Converts a byte stream (ASCII text plus control codes) into VRAM writes (data, address, write-enable) with cursor tracking, auto-wrap, line clearing and hardware vertical scroll.
- The character generator consumes VRAM_WDs_o/VRAM_WAs_o/VRAM_WE_o on its VRAM write port and V_SCROLLs_o on its BUS_V_SCROLLs input.
- Runs on the 4fsc-enable domain: all state advances only when CK_EE_i=1.
- Screen geometry is fixed: 32 columns x 32 rows = 1024 cells, 8-line font.

Parameters:
- C_FILL_CHR, 8'h20: code written by all clear operations.
- C_LF_CR, 1: 1 = LF also returns the column to 0; 0 = LF keeps the column.
- C_AUTO_WRAP, 1: 1 = a write at column 31 performs a newline; 0 = the cursor stays at column 31.

Ports:
- CK_i  in  1  system clock
- AR_i  in  1  asynchronous reset, active-high
- CK_EE_i  in  1  clock enable (one CK_i cycle in four)
- DAT_i  in  8  input byte
- DAT_VALID_i  in  1  DAT_i valid
- DAT_READY_o  out  1  console can accept a byte
- VRAM_WDs_o  out  8  VRAM write data
- VRAM_WAs_o  out  10  VRAM write address, {phys_row[4:0], col[4:0]}
- VRAM_WE_o  out  1  VRAM write strobe
- V_SCROLLs_o  out  8  vertical scroll in lines = TOP_ROW*8
- CUR_COLs_o  out  5  cursor column
- CUR_ROWs_o  out  5  cursor logical row (0 = top of screen)
- BUSY_o  out  1  clear in progress

Behaviour:
- Reset: AR_i is asynchronous and active-high; all registers are clocked on CK_i.
- Every register update below happens only on CK_i edges with CK_EE_i=1. "Enable" means such an edge.
- Reset values:
  - WE=0, WDs=0, WAs=0, V_SCROLLs=0, COL=0, ROW=0, TOP_ROW=0, READY=0, BUSY=1.
  - State = CLR_ALL with CLR_CTR=0, so the screen is cleared automatically after reset.
  - Reset during any state aborts it immediately and restarts from these values.
- Handshake: a byte is accepted on an enable where DAT_VALID_i=1 and DAT_READY_o=1. DAT_READY_o=1 only in IDLE. After every acceptance DAT_READY_o is 0 for at least one enable, so peak throughput is one byte per 2 enables.
- Physical row: PROW = (TOP_ROW+ROW) mod 32 (5-bit wrap).
- States:
  - IDLE: READY=1, WE=0. On acceptance, decode the byte:
    - Printable byte (>=0x20, including 0x7F-0xFF): WDs=DAT_i, WAs={PROW,COL}, WE=1 → WRITE.
    - 0x0D (CR): COL=0 → WRITE (no strobe).
    - 0x0A (LF): perform NEWLINE. COL=0 if C_LF_CR=1.
    - 0x08 (BS): COL=COL-1 if COL>0, else unchanged. The cell is not erased.
    - 0x0C (FF): COL=0, ROW=0, TOP_ROW=0, V_SCROLLs=0 → CLR_ALL.
    - Any other byte <0x20: consumed, no effect → WRITE (no strobe).
  - WRITE: lasts one enable, READY=0. WE drops at the next enable. Cursor advance happens on leaving WRITE:
    - COL<31: COL+1.
    - COL=31 and C_AUTO_WRAP=1: NEWLINE with COL=0.
    - COL=31 and C_AUTO_WRAP=0: COL stays 31.
    - Then → IDLE (or CLR_LINE if NEWLINE scrolled).
  - NEWLINE (action, not a state):
    - ROW<31: ROW+1 → IDLE (via one READY=0 enable).
    - ROW=31: TOP_ROW+1 (wraps 31→0), V_SCROLLs=new TOP_ROW*8, ROW stays 31, CLR_CTR=0 → CLR_LINE.
  - CLR_LINE:
    - 32 consecutive enables with WE=1, WDs=C_FILL_CHR, WAs={new bottom PROW, CLR_CTR}. CLR_CTR runs 0..31.
    - BUSY=1, READY=0. After CLR_CTR=31 → IDLE.
  - CLR_ALL:
    - 1024 consecutive enables with WE=1, WDs=C_FILL_CHR, WAs=CLR_CTR. CLR_CTR runs 0..1023.
    - BUSY=1, READY=0. After CLR_CTR=1023 → IDLE, with WE=0 at the following enable.
- V_SCROLLs_o updates at the same enable as TOP_ROW, before the line clear begins.
- CUR_COLs_o and CUR_ROWs_o are registered and reflect the cursor after every update.
- DAT_VALID_i while READY=0 is ignored. The source must hold the byte until it is accepted.

Test Plan:
- Release reset, CK_EE every 4th CK → exactly 1024 strobes, WAs 0..1023 ascending, WDs=0x20; BUSY falls and READY rises at the 1025th enable.
- Send "AB" → 2 strobes: (WAs=0x000, 0x41) then (WAs=0x001, 0x42); final COL=2, ROW=0.
- From COL=31, ROW=0, send 'Z' → write at WAs=0x01F; cursor becomes COL=0, ROW=1. Repeat with C_AUTO_WRAP=0 → cursor stays COL=31, ROW=0.
- At ROW=31, TOP_ROW=0, send LF → V_SCROLLs=8; 32 strobes of 0x20 at WAs 0x000..0x01F; next 'Q' written at WAs=0x000. After 32 such scrolls, V_SCROLLs wraps to 0.
- Send BS at COL=0 → no change; send BS at COL=5 → COL=4, no strobe. Send FF mid-screen → cursor homes, V_SCROLLs=0, 1024 clear strobes.
- Assert AR_i midway through CLR_LINE → WE=0 immediately; the CLR_ALL sequence restarts from address 0 after release.
